iir_cfg_ctrl: RTL
=================

Name: iir_cfg_ctrl

Overview:
Configuration and sequencing controller placed in front of iir_filter. It holds shadow and active coefficient banks and passes upstream samples to the filter through one register stage. On a commit request it stalls the upstream source and drains the samples still in the filter pipeline. It then swaps the shadow bank into the active bank, so no sample is ever processed with a partly updated coefficient set.

Parameters:
NB, 12, sample and coefficient word width
LAT, 4, filter pipeline depth in cycles (dIn accepted to vOut); drain length
CW, 4, drain counter width; must satisfy 2^CW > LAT

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
s_vld  in  1  upstream sample valid
s_data  in  NB  upstream sample
s_rdy  out  1  upstream ready; a sample transfers when s_vld & s_rdy
f_vIn  out  1  to filter vIn
f_dIn  out  NB  to filter dIn
f_b  out  3*NB  active b coefficients {b2,b1,b0}, b0 in the LSBs
f_a  out  2*NB  active a coefficients {a2,a1}, a1 in the LSBs
cfg_we  in  1  coefficient write strobe
cfg_addr  in  3  0=b0 1=b1 2=b2 3=a1 4=a2
cfg_data  in  NB  coefficient value, two's complement
cfg_commit  in  1  request a shadow-to-active swap
cfg_busy  out  1  high while state is not IDLE
cfg_err  out  1  one-cycle error pulse
commit_done  out  1  one-cycle pulse, first cycle the new coefficients are on f_b/f_a

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled on clk.
- Reset values: state IDLE; shadow bank 0; active bank 0 (f_b=0, f_a=0); f_vIn=0; f_dIn=0; cfg_err=0; commit_done=0; drain counter 0.
- Reset mid-operation: same reset values apply from any state. An in-progress drain is abandoned and the shadow contents are lost.
- States:
  - IDLE: s_rdy=1.
  - DRAIN: s_rdy=0.
  - SWAP: s_rdy=0.
  - s_rdy is decoded from state only; it never depends on s_vld.
- Datapath:
  - f_vIn <= s_vld & s_rdy, registered, every cycle.
  - f_dIn <= s_data when a transfer happens; otherwise it holds its previous value.
  - Latency s_data to f_dIn is 1 cycle.
- Shadow writes, accepted in IDLE only:
  - cfg_we with addr 0-4 writes that shadow word at the clock edge.
  - addr 5-7: the write is dropped and cfg_err pulses on the next cycle.
  - cfg_we in DRAIN or SWAP: the write is dropped and cfg_err pulses.
- IDLE to DRAIN: cfg_commit=1 in IDLE moves to DRAIN and loads counter = LAT-1.
  - A cfg_we in the same cycle lands in shadow and is included in the swap.
  - A sample transferring in the same cycle is still forwarded, because that cycle is IDLE.
- DRAIN: if counter==0 go to SWAP, else counter decrements by 1.
  - DRAIN lasts exactly LAT cycles; LAT=0 is treated as 1.
- SWAP, one cycle: active <= shadow; next state IDLE; commit_done <= 1.
  - commit_done and the new f_b/f_a appear together on the first IDLE cycle.
- Stall length: s_rdy is low for LAT+1 consecutive cycles per commit.
- f_vIn during DRAIN and SWAP: f_vIn=0, except in the first DRAIN cycle, which carries the sample accepted in the commit cycle.
- cfg_commit in DRAIN or SWAP: ignored and cfg_err pulses. The shadow bank is unchanged.
- Simultaneous errors in one cycle: a single cfg_err pulse.
- Back-to-back commits: a commit in the first IDLE cycle after SWAP is legal and starts a new drain.
- Shadow persistence: shadow is never cleared by a commit. A commit with no prior writes re-applies the same values with no visible change except the stall.
- cfg_busy is high in DRAIN and SWAP.
- No arithmetic is done on coefficients; words are stored and concatenated exactly as written.

Test Plan:
1. Reset, then s_vld=1 with s_data=0x123 -> s_rdy=1; f_vIn=1 and f_dIn=0x123 one cycle later; f_b=0 and f_a=0.
2. Write b0=0x400, b1=0x200, b2=0x100, a1=0xF00, a2=0x080, then commit (LAT=4) -> s_rdy low for 5 cycles; cfg_busy high for 5 cycles; commit_done pulses once; then f_b=0x100200400 and f_a=0x080F00.
3. Continuous s_vld with commit in cycle k -> the sample of cycle k appears on f_vIn at k+1; f_vIn=0 for k+2..k+5; transfers resume at k+6; no sample is lost or duplicated.
4. Write during DRAIN (addr 0, 0x7FF), and commit during SWAP -> both dropped; cfg_err pulses; after the next commit b0 is still 0x400.
5. Write to addr 6 in IDLE -> cfg_err pulse; shadow unchanged. cfg_we to addr 2 and cfg_commit in the same cycle -> the new b2 is visible after commit_done.
6. rst_n=0 in the second DRAIN cycle -> next cycle state IDLE, s_rdy=1, f_b=0, f_a=0, commit_done never pulses.

Source files
------------

// File: rtl/iir_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// iir_cfg_ctrl_if
// Bundles the sample stream, the filter-side outputs and the coefficient
// configuration bus of iir_cfg_ctrl into one interface.
//   master : upstream/config side (drives s_vld, s_data, cfg_*)
//   slave  : the controller (drives s_rdy, f_*, cfg_busy, cfg_err,
//            commit_done)
// Parameter NB is the sample/coefficient word width.
// ---------------------------------------------------------------------------
interface iir_cfg_ctrl_if #(
    parameter int NB = 12
);
    logic            s_vld;
    logic [NB-1:0]   s_data;
    logic            s_rdy;
    logic            f_vIn;
    logic [NB-1:0]   f_dIn;
    logic [3*NB-1:0] f_b;
    logic [2*NB-1:0] f_a;
    logic            cfg_we;
    logic [2:0]      cfg_addr;
    logic [NB-1:0]   cfg_data;
    logic            cfg_commit;
    logic            cfg_busy;
    logic            cfg_err;
    logic            commit_done;

    modport master (
        output s_vld, s_data, cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  s_rdy, f_vIn, f_dIn, f_b, f_a, cfg_busy, cfg_err, commit_done
    );

    modport slave (
        input  s_vld, s_data, cfg_we, cfg_addr, cfg_data, cfg_commit,
        output s_rdy, f_vIn, f_dIn, f_b, f_a, cfg_busy, cfg_err, commit_done
    );
endinterface

// File: rtl/iir_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// iir_cfg_ctrl
// Configuration and sequencing controller in front of iir_filter. Samples
// pass to the filter through one register stage. Coefficients are written
// into a shadow bank; a commit stalls the upstream source, drains the LAT
// samples still inside the filter, then copies shadow into the active bank
// in one cycle so the filter never sees a half-updated coefficient set.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : iir_cfg_ctrl_if.slave (sample stream, filter outputs, cfg bus)
// Parameters: NB word width, LAT filter depth / drain length, CW counter
// width (2^CW > LAT).
// ---------------------------------------------------------------------------
module iir_cfg_ctrl #(
    parameter int NB  = 12,
    parameter int LAT = 4,
    parameter int CW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    iir_cfg_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    // LAT=0 still gets one drain cycle, so the load value saturates at 0.
    localparam logic [CW-1:0] DRAIN_LOAD = (LAT > 1) ? CW'(LAT - 1) : '0;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [4:0][NB-1:0] shadow;
    logic [4:0][NB-1:0] active;
    logic              s_rdy;
    logic              shadow_we;
    logic              err_next;
    logic              swap;
    logic              f_vld_q;
    logic [NB-1:0]     f_data_q;
    logic              err_q;
    logic              done_q;

    // Next-state and decoded outputs. Any config access outside IDLE is
    // rejected; write and commit errors in the same cycle merge into one
    // pulse because they share err_next.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        s_rdy      = 1'b0;
        shadow_we  = 1'b0;
        err_next   = 1'b0;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                s_rdy = 1'b1;
                if (bus.cfg_we) begin
                    if (bus.cfg_addr <= 3'd4) begin
                        shadow_we = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                if (bus.cfg_commit) begin
                    state_next = DRAIN;
                    cnt_next   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                err_next = bus.cfg_we | bus.cfg_commit;
                if (cnt == '0) begin
                    state_next = SWAP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            SWAP: begin
                err_next   = bus.cfg_we | bus.cfg_commit;
                swap       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and drain counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sample stage: valid is registered every cycle, data only loads on a
    // transfer so it holds the last forwarded sample otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_vld_q  <= 1'b0;
            f_data_q <= '0;
        end else begin
            f_vld_q <= bus.s_vld & s_rdy;
            if (bus.s_vld && s_rdy) begin
                f_data_q <= bus.s_data;
            end
        end
    end

    // Coefficient banks plus the one-cycle status pulses. commit_done is
    // registered off SWAP so it lines up with the new active bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            err_q  <= err_next;
            done_q <= swap;
            if (shadow_we) begin
                case (bus.cfg_addr)
                    3'd0:    shadow[0] <= bus.cfg_data;
                    3'd1:    shadow[1] <= bus.cfg_data;
                    3'd2:    shadow[2] <= bus.cfg_data;
                    3'd3:    shadow[3] <= bus.cfg_data;
                    3'd4:    shadow[4] <= bus.cfg_data;
                    default: ;
                endcase
            end
            if (swap) begin
                active <= shadow;
            end
        end
    end

    assign bus.s_rdy       = s_rdy;
    assign bus.cfg_busy    = (state != IDLE);
    assign bus.f_vIn       = f_vld_q;
    assign bus.f_dIn       = f_data_q;
    assign bus.f_b         = {active[2], active[1], active[0]};
    assign bus.f_a         = {active[4], active[3]};
    assign bus.cfg_err     = err_q;
    assign bus.commit_done = done_q;

endmodule
